// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: line configuration type, its enums, the receiver
// state encoding and the baud divisor helper used by both the transmitter and
// the receiver so that their bit periods always agree.
package uart_receiver_pkg;

  // Width of bit-period counters; covers CLK_FREQ / 9600 well past 1 GHz.
  localparam int CNT_W = 20;

  typedef enum logic [2:0] {
    BAUD_9600   = 3'd0,
    BAUD_19200  = 3'd1,
    BAUD_38400  = 3'd2,
    BAUD_57600  = 3'd3,
    BAUD_115200 = 3'd4
  } baud_rate_t;

  typedef enum logic [1:0] {
    DATA_5 = 2'd0,
    DATA_6 = 2'd1,
    DATA_7 = 2'd2,
    DATA_8 = 2'd3
  } data_bits_t;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_t;

  typedef enum logic [1:0] {
    STOP_1   = 2'd0,
    STOP_1_5 = 2'd1,
    STOP_2   = 2'd2
  } stop_bits_t;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } bit_order_t;

  typedef struct packed {
    baud_rate_t baud_rate;
    data_bits_t data_bits;
    parity_t    parity;
    stop_bits_t stop_bits;
    bit_order_t bit_order;
  } uart_config_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Clock cycles per bit. Each branch divides by a literal, so with a
  // constant clk_freq this reduces to a small mux of constants.
  // Unknown codes fall back to 9600 baud.
  function automatic logic [CNT_W-1:0] baud_cycles(input int unsigned clk_freq,
                                                   input baud_rate_t  baud_code);
    logic [CNT_W-1:0] cycles;
    case (baud_code)
      BAUD_19200:  cycles = CNT_W'(clk_freq / 19200);
      BAUD_38400:  cycles = CNT_W'(clk_freq / 38400);
      BAUD_57600:  cycles = CNT_W'(clk_freq / 57600);
      BAUD_115200: cycles = CNT_W'(clk_freq / 115200);
      default:     cycles = CNT_W'(clk_freq / 9600);
    endcase
    return cycles;
  endfunction

endpackage

// File: rtl/uart_receiver_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input.
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset; both flops reset to 1 (idle level)
//   d     - asynchronous input
//   q     - synchronized output, two cycles behind d
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: detects a start bit on the synchronized RX line, samples
// each bit at mid-period, assembles 5-8 data bits LSB- or MSB-first, checks
// parity and the first stop bit, and presents each frame with a strobe.
// Ports:
//   clk, rst_n    - clock, synchronous active-low reset
//   rx            - asynchronous serial input, idle high
//   uart_config   - baud/data bits/parity/stop bits/bit order
//   rx_data       - frame data, zero above the configured width
//   rx_valid      - one-cycle strobe when a frame completes
//   parity_error  - parity mismatch, qualified by rx_valid
//   framing_error - first stop bit sampled low, qualified by rx_valid
//   busy          - receiver is not idle
//   state         - current FSM state, for observation
// Handshake: rx_valid is a push-only strobe with no ready; rx_data and the
// error flags are valid in the rx_valid cycle and hold until the next one.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 1843200
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx,
  input  uart_config_t uart_config,
  output logic [7:0]   rx_data,
  output logic         rx_valid,
  output logic         parity_error,
  output logic         framing_error,
  output logic         busy,
  output rx_state_t    state
);

  logic             rx_s, rx_prev;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cpb_q, cpb_d;
  logic [3:0]       nbits_q, nbits_d;
  parity_t          parity_q, parity_d;
  bit_order_t       order_q, order_d;
  logic [2:0]       idx_q, idx_d, pos;
  logic [7:0]       shift_q, shift_d, rx_data_d;
  logic             acc_q, acc_d, perr_q, perr_d;
  logic             rx_valid_d, perr_out_d, ferr_out_d;
  logic             half_tick, bit_tick, last_bit;

  // Stop-bit length only matters to the transmitter; the receiver returns
  // to idle at the middle of the first stop bit.
  logic unused_stop_bits;
  assign unused_stop_bits = ^uart_config.stop_bits;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign half_tick = (cnt_q == (cpb_q >> 1) - CNT_W'(1));
  assign bit_tick  = (cnt_q == cpb_q - CNT_W'(1));
  assign last_bit  = ({1'b0, idx_q} == nbits_q - 4'd1);
  assign pos       = (order_q == MSB_FIRST) ? 3'(nbits_q - 4'd1 - {1'b0, idx_q}) : idx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_prev       <= 1'b1;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      cpb_q         <= '0;
      nbits_q       <= 4'd8;
      parity_q      <= PARITY_NONE;
      order_q       <= LSB_FIRST;
      idx_q         <= '0;
      shift_q       <= '0;
      acc_q         <= 1'b0;
      perr_q        <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      rx_prev       <= rx_s;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cpb_q         <= cpb_d;
      nbits_q       <= nbits_d;
      parity_q      <= parity_d;
      order_q       <= order_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      acc_q         <= acc_d;
      perr_q        <= perr_d;
      rx_data       <= rx_data_d;
      rx_valid      <= rx_valid_d;
      parity_error  <= perr_out_d;
      framing_error <= ferr_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cpb_d      = cpb_q;
    nbits_d    = nbits_q;
    parity_d   = parity_q;
    order_d    = order_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    perr_d     = perr_q;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
    perr_out_d = parity_error;
    ferr_out_d = framing_error;
    case (state_q)
      ST_IDLE: begin
        // A falling edge is required, so a line stuck low never restarts.
        if (rx_prev && !rx_s) begin
          state_d  = ST_START;
          cnt_d    = '0;
          cpb_d    = baud_cycles(CLK_FREQ, uart_config.baud_rate);
          nbits_d  = {2'b00, uart_config.data_bits} + 4'd5;
          parity_d = uart_config.parity;
          order_d  = uart_config.bit_order;
          shift_d  = '0;
          perr_d   = 1'b0;
        end
      end
      ST_START: begin
        if (half_tick) begin
          if (!rx_s) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            idx_d   = '0;
            acc_d   = (parity_q == PARITY_ODD);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          cnt_d        = '0;
          shift_d[pos] = rx_s;
          acc_d        = acc_q ^ rx_s;
          idx_d        = idx_q + 3'd1;
          if (last_bit) begin
            state_d = (parity_q == PARITY_NONE) ? ST_STOP : ST_PARITY;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          cnt_d   = '0;
          perr_d  = (rx_s != acc_q);
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        // Outputs register on this edge, so rx_valid rises the cycle after
        // the mid-stop sample while the FSM is already back in idle.
        if (bit_tick) begin
          state_d    = ST_IDLE;
          rx_valid_d = 1'b1;
          rx_data_d  = shift_q;
          perr_out_d = perr_q;
          ferr_out_d = !rx_s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy  = (state_q != ST_IDLE);
  assign state = state_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 1843200 Hz / 115200 baud (16 cycles
// per bit). Line vectors are written LSB-transmitted-first:
// bit 0 is the start bit, followed by data, optional parity, and stop.
module tb_uart_receiver;
  import uart_receiver_pkg::*;

  localparam int BIT_CYC = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx = 1'b1;
  uart_config_t cfg;
  logic [7:0]   rx_data;
  logic         rx_valid, parity_error, framing_error, busy;
  rx_state_t    state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // Captured frame results, updated on every rx_valid cycle.
  int         valid_cnt = 0;
  logic [7:0] cap_data  = 8'h00;
  logic       cap_perr  = 1'b0;
  logic       cap_ferr  = 1'b0;

  uart_receiver #(.CLK_FREQ(1843200)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .uart_config   (cfg),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .busy          (busy),
    .state         (state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt = valid_cnt + 1;
      cap_data  = rx_data;
      cap_perr  = parity_error;
      cap_ferr  = framing_error;
    end
  end

  // Driver tasks
  task automatic line(input logic b, input int cycles);
    rx = b;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) line(bits[i], BIT_CYC);
  endtask

  task automatic set_cfg(input data_bits_t db, input parity_t p, input bit_order_t o);
    cfg.baud_rate = BAUD_115200;
    cfg.data_bits = db;
    cfg.parity    = p;
    cfg.stop_bits = STOP_1;
    cfg.bit_order = o;
  endtask

  // Checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag, input int exp_cnt, input logic [7:0] d,
                             input logic pe, input logic fe);
    check({tag, "_count"}, 32'(valid_cnt), 32'(exp_cnt));
    check({tag, "_data"},  32'(cap_data),  32'(d));
    check({tag, "_held"},  32'(rx_data),   32'(d));
    check({tag, "_perr"},  32'(cap_perr),  32'(pe));
    check({tag, "_ferr"},  32'(cap_ferr),  32'(fe));
    check({tag, "_busy"},  32'(busy),      32'(0));
  endtask

  // Directed sequence
  initial begin
    set_cfg(DATA_8, PARITY_NONE, LSB_FIRST);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data",  32'(rx_data),       32'(0));
    check("rst_valid", 32'(rx_valid),      32'(0));
    check("rst_perr",  32'(parity_error),  32'(0));
    check("rst_ferr",  32'(framing_error), 32'(0));
    check("rst_busy",  32'(busy),          32'(0));
    check("rst_state", 32'(state_dbg),     32'(ST_IDLE));
    rst_n = 1'b1;
    line(1'b1, 8);

    // 8N1 LSB-first 0xA5
    send_bits({6'b0, 1'b1, 8'hA5, 1'b0}, 10);
    line(1'b1, 8);
    check_frame("f8n1_a5", 1, 8'hA5, 1'b0, 1'b0);

    // 7E1 0x41: two ones, so even parity bit is 0; then a wrong parity bit
    set_cfg(DATA_7, PARITY_EVEN, LSB_FIRST);
    send_bits({6'b0, 1'b1, 1'b0, 7'h41, 1'b0}, 10);
    line(1'b1, 8);
    check_frame("f7e1_ok", 2, 8'h41, 1'b0, 1'b0);
    send_bits({6'b0, 1'b1, 1'b1, 7'h41, 1'b0}, 10);
    line(1'b1, 8);
    check_frame("f7e1_perr", 3, 8'h41, 1'b1, 1'b0);

    // 5O1 MSB-first, line data 1,0,1,1,0 -> 0x16, three ones so odd parity bit 0
    set_cfg(DATA_5, PARITY_ODD, MSB_FIRST);
    send_bits(16'b0000_0000_1001_1010, 8);
    line(1'b1, 8);
    check_frame("f5o1_msb", 4, 8'h16, 1'b0, 1'b0);

    // 8N1 0x3C with stop bit low, line held low 40 more cycles
    set_cfg(DATA_8, PARITY_NONE, LSB_FIRST);
    send_bits({6'b0, 1'b0, 8'h3C, 1'b0}, 10);
    line(1'b0, 40);
    check_frame("f_ferr", 5, 8'h3C, 1'b0, 1'b1);
    line(1'b1, 20);
    send_bits({6'b0, 1'b1, 8'h55, 1'b0}, 10);
    line(1'b1, 8);
    check_frame("f_after_break", 6, 8'h55, 1'b0, 1'b0);

    // 4-cycle glitch: start detected, rejected at the half-bit sample
    line(1'b0, 4);
    check("glitch_busy", 32'(busy), 32'(1));
    line(1'b1, 12);
    check("glitch_idle",     32'(busy),      32'(0));
    check("glitch_no_valid", 32'(valid_cnt), 32'(6));
    check("glitch_hold",     32'(rx_data),   32'(8'h55));

    // Reset in the middle of data bit 3 of 0xF8 (line stays high afterwards)
    send_bits(16'h0000, 4);
    line(1'b1, 8);
    check("pre_rst_busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy",  32'(busy),      32'(0));
    check("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("mid_rst_data",  32'(rx_data),   32'(0));
    check("mid_rst_valid", 32'(rx_valid),  32'(0));
    line(1'b1, 4);
    rst_n = 1'b1;
    line(1'b1, 6 * BIT_CYC);
    check("mid_rst_no_valid", 32'(valid_cnt), 32'(6));
    check("mid_rst_idle",     32'(busy),      32'(0));

    // Back-to-back 0x01 then 0xFF; config switches to 7E1 during the second
    set_cfg(DATA_8, PARITY_NONE, LSB_FIRST);
    send_bits({6'b0, 1'b1, 8'h01, 1'b0}, 10);
    check_frame("b2b_first", 7, 8'h01, 1'b0, 1'b0);
    send_bits({11'b0, 5'b11110}, 5);
    set_cfg(DATA_7, PARITY_EVEN, LSB_FIRST);
    send_bits({11'b0, 5'b11111}, 5);
    line(1'b1, 8);
    check_frame("b2b_second", 8, 8'hFF, 1'b0, 1'b0);

    // Following frame uses the new 7E1 config: 0x2A has three ones -> parity 1
    send_bits({6'b0, 1'b1, 1'b1, 7'h2A, 1'b0}, 10);
    line(1'b1, 8);
    check_frame("cfg_next", 9, 8'h2A, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
